// File: rtl/l1i_miss_ctrl.sv
// l1i_miss_ctrl: per-SM L1I miss merging, round-robin L2 fill issue and thread wakeup
module l1i_miss_ctrl #(
  parameter int NUM_THREADS = 4,
  parameter int LINE_ADDR_WIDTH = 26,
  localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       miss_valid,
  input  logic [TW-1:0]              miss_thread_idx,
  input  logic [LINE_ADDR_WIDTH-1:0] miss_line_addr,
  output logic                       l2_req_valid,
  input  logic                       l2_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0] l2_req_addr,
  input  logic                       l2_resp_valid,
  input  logic [LINE_ADDR_WIDTH-1:0] l2_resp_addr,
  output logic [NUM_THREADS-1:0]     wake_bitmap,
  output logic [NUM_THREADS-1:0]     thread_waiting
);
  logic [NUM_THREADS-1:0]     valid, issued, mmatch, rmatch, cand, tbit, rwake;
  logic [LINE_ADDR_WIDTH-1:0] addr [NUM_THREADS];
  logic [NUM_THREADS-1:0]     waiters [NUM_THREADS];
  logic [TW-1:0]              req_idx, ptr, ptr_n, sel;
  logic                       hs, miss_ok, collide, merge, alloc, found;
  // match misses and responses against the table, pick the next round-robin candidate
  always_comb begin
    hs = l2_req_valid && l2_req_ready;
    tbit = NUM_THREADS'(1) << miss_thread_idx;
    mmatch = '0;
    rmatch = '0;
    rwake = '0;
    thread_waiting = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      mmatch[i] = valid[i] && addr[i] == miss_line_addr;
      rmatch[i] = valid[i] && issued[i] && addr[i] == l2_resp_addr && l2_resp_valid;
      rwake = rwake | (rmatch[i] ? waiters[i] : '0);
      thread_waiting = thread_waiting | (valid[i] ? waiters[i] : '0);
    end
    miss_ok = miss_valid && !thread_waiting[miss_thread_idx];
    collide = miss_ok && l2_resp_valid && miss_line_addr == l2_resp_addr;
    merge = miss_ok && !collide && |mmatch;
    alloc = miss_ok && !collide && !merge;
    ptr_n = hs ? req_idx : ptr;
    cand = (valid & ~issued & ~(hs ? NUM_THREADS'(1) << req_idx : '0)) | (alloc ? tbit : '0);
    found = 1'b0;
    sel = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      if (!found && cand[(int'(ptr_n) + i) % NUM_THREADS]) begin
        found = 1'b1;
        sel = TW'((int'(ptr_n) + i) % NUM_THREADS);
      end
    end
  end
  // update entries, present/hold the fill request and pulse wakeups
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      issued <= '0;
      l2_req_valid <= 1'b0;
      l2_req_addr <= '0;
      req_idx <= '0;
      ptr <= '0;
      wake_bitmap <= '0;
    end else begin
      wake_bitmap <= rwake | (collide ? tbit : '0);
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (rmatch[i]) valid[i] <= 1'b0;
        if (merge && mmatch[i]) waiters[i] <= waiters[i] | tbit;
      end
      if (hs) issued[req_idx] <= 1'b1;
      if (alloc) begin
        valid[miss_thread_idx] <= 1'b1;
        issued[miss_thread_idx] <= 1'b0;
        addr[miss_thread_idx] <= miss_line_addr;
        waiters[miss_thread_idx] <= tbit;
      end
      if (!l2_req_valid || l2_req_ready) begin
        l2_req_valid <= found;
        l2_req_addr <= !found ? l2_req_addr : (alloc && sel == miss_thread_idx) ? miss_line_addr : addr[sel];
        req_idx <= sel;
      end
      ptr <= ptr_n;
    end
  end
  // a blocked thread must not report another miss
  always_ff @(posedge clk) if (!reset && miss_valid) assert (!thread_waiting[miss_thread_idx]);
endmodule

// File: tb/tb_l1i_miss_ctrl.sv
// tb_l1i_miss_ctrl: directed scenarios plus randomized traffic against a line-level model
module tb_l1i_miss_ctrl;
  localparam int N = 4;
  localparam int AW = 26;
  logic clk = 0, reset = 1, miss_valid = 0, l2_req_ready = 0, l2_resp_valid = 0;
  logic [1:0] miss_thread_idx = 0;
  logic [AW-1:0] miss_line_addr = 0, l2_resp_addr = 0, l2_req_addr;
  logic l2_req_valid;
  logic [N-1:0] wake_bitmap, thread_waiting;
  int checks = 0, errors = 0;
  bit [N-1:0] wt [int];
  bit iss [int];
  always #5 clk = ~clk;
  l1i_miss_ctrl #(.NUM_THREADS(N), .LINE_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_thread_idx(miss_thread_idx),
    .miss_line_addr(miss_line_addr), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_addr(l2_req_addr), .l2_resp_valid(l2_resp_valid), .l2_resp_addr(l2_resp_addr),
    .wake_bitmap(wake_bitmap), .thread_waiting(thread_waiting));
  task automatic drive(input logic mv, input logic [1:0] mt, input logic [AW-1:0] ma,
                       input logic rdy, input logic rv, input logic [AW-1:0] ra);
    miss_valid = mv; miss_thread_idx = mt; miss_line_addr = ma;
    l2_req_ready = rdy; l2_resp_valid = rv; l2_resp_addr = ra;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic bit [N-1:0] mwait();
    bit [N-1:0] w = '0;
    foreach (wt[k]) w |= wt[k];
    return w;
  endfunction
  task automatic test_reset;
    reset = 1; drive(0, 0, 0, 0, 0, 0); tick; tick; reset = 0;
    checks++; if ({l2_req_valid, l2_req_addr, wake_bitmap, thread_waiting} !== '0) begin errors++;
      $display("FAIL reset_outputs got v=%0b a=%h w=%b tw=%b want all 0", l2_req_valid, l2_req_addr, wake_bitmap, thread_waiting); end
  endtask
  task automatic test_single;
    drive(1, 2, 26'h1234, 1, 0, 0); tick;
    checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 26'h1234) begin errors++;
      $display("FAIL single_req got v=%0b a=%h want v=1 a=0001234", l2_req_valid, l2_req_addr); end
    checks++; if (thread_waiting !== 4'b0100) begin errors++;
      $display("FAIL single_waiting got %b want 0100", thread_waiting); end
    drive(0, 0, 0, 1, 0, 0); tick;
    checks++; if (l2_req_valid !== 1'b0) begin errors++;
      $display("FAIL single_req_drop got %0b want 0", l2_req_valid); end
    drive(0, 0, 0, 0, 0, 0); tick; tick;
    drive(0, 0, 0, 0, 1, 26'h1234); tick;
    checks++; if (wake_bitmap !== 4'b0100 || thread_waiting !== 4'b0000) begin errors++;
      $display("FAIL single_wake got w=%b tw=%b want w=0100 tw=0000", wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 0, 0, 0); tick;
    checks++; if (wake_bitmap !== 4'b0000) begin errors++;
      $display("FAIL single_wake_pulse got %b want 0000", wake_bitmap); end
  endtask
  task automatic test_merge;
    int n = 0;
    drive(1, 0, 26'h55, 0, 0, 0); tick;
    drive(1, 3, 26'h55, 1, 0, 0);
    checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 26'h55) begin errors++;
      $display("FAIL merge_req got v=%0b a=%h want v=1 a=55", l2_req_valid, l2_req_addr); end
    if (l2_req_valid && l2_req_ready) n++;
    tick;
    drive(0, 0, 0, 1, 0, 0);
    repeat (4) begin if (l2_req_valid && l2_req_ready) n++; tick; end
    checks++; if (n !== 1) begin errors++; $display("FAIL merge_req_count got %0d want 1", n); end
    checks++; if (thread_waiting !== 4'b1001) begin errors++;
      $display("FAIL merge_waiting got %b want 1001", thread_waiting); end
    drive(0, 0, 0, 0, 1, 26'h55); tick;
    checks++; if (wake_bitmap !== 4'b1001 || thread_waiting !== 4'b0000) begin errors++;
      $display("FAIL merge_wake got w=%b tw=%b want w=1001 tw=0000", wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 0, 0, 0); tick;
    checks++; if (wake_bitmap !== 4'b0000) begin errors++;
      $display("FAIL merge_wake_pulse got %b want 0000", wake_bitmap); end
  endtask
  task automatic test_round_robin;
    logic [AW-1:0] exp_a [3] = '{26'h10, 26'h20, 26'h30};
    for (int k = 0; k < 3; k++) begin drive(1, 2'(k), exp_a[k], 0, 0, 0); tick; end
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== 26'h10) begin errors++;
        $display("FAIL rr_hold cycle %0d got v=%0b a=%h want v=1 a=10", k, l2_req_valid, l2_req_addr); end
      tick;
    end
    drive(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== exp_a[k]) begin errors++;
        $display("FAIL rr_order %0d got v=%0b a=%h want v=1 a=%h", k, l2_req_valid, l2_req_addr, exp_a[k]); end
      tick;
    end
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %0b want 0", l2_req_valid); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, exp_a[k]); tick;
      checks++; if (wake_bitmap !== 4'(1 << k)) begin errors++;
        $display("FAIL rr_wake %0d got %b want %b", k, wake_bitmap, 4'(1 << k)); end
    end
    drive(0, 0, 0, 0, 0, 0); tick;
  endtask
  task automatic test_collision;
    drive(1, 0, 26'h77, 1, 0, 0); tick;
    drive(0, 0, 0, 1, 0, 0); tick;
    drive(1, 1, 26'h77, 1, 1, 26'h77); tick;
    checks++; if (wake_bitmap !== 4'b0011 || thread_waiting !== 4'b0000) begin errors++;
      $display("FAIL collide_wake got w=%b tw=%b want w=0011 tw=0000", wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 1, 0, 0);
    checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL collide_no_req got %0b want 0", l2_req_valid); end
    tick;
    checks++; if (l2_req_valid !== 1'b0 || wake_bitmap !== 4'b0000) begin errors++;
      $display("FAIL collide_after got v=%0b w=%b want v=0 w=0000", l2_req_valid, wake_bitmap); end
  endtask
  task automatic test_stray;
    drive(1, 2, 26'hAA, 1, 0, 0); tick;
    drive(0, 0, 0, 1, 0, 0); tick;
    drive(0, 0, 0, 0, 1, 26'h99); tick;
    checks++; if (wake_bitmap !== 4'b0000 || thread_waiting !== 4'b0100 || l2_req_valid !== 1'b0) begin errors++;
      $display("FAIL stray got w=%b tw=%b v=%0b want w=0000 tw=0100 v=0", wake_bitmap, thread_waiting, l2_req_valid); end
    drive(0, 0, 0, 0, 1, 26'hAA); tick;
    checks++; if (wake_bitmap !== 4'b0100 || thread_waiting !== 4'b0000) begin errors++;
      $display("FAIL stray_real_wake got w=%b tw=%b want w=0100 tw=0000", wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 0, 0, 0); tick;
  endtask
  task automatic test_reset_midflight;
    drive(1, 0, 26'h200, 1, 0, 0); tick;
    drive(1, 1, 26'h300, 1, 0, 0); tick;
    drive(0, 0, 0, 1, 0, 0); tick;
    checks++; if (thread_waiting !== 4'b0011) begin errors++;
      $display("FAIL midrst_waiting got %b want 0011", thread_waiting); end
    reset = 1; drive(0, 0, 0, 0, 0, 0); tick; reset = 0;
    checks++; if ({l2_req_valid, l2_req_addr, wake_bitmap, thread_waiting} !== '0) begin errors++;
      $display("FAIL midrst_outputs got v=%0b a=%h w=%b tw=%b want all 0", l2_req_valid, l2_req_addr, wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 0, 1, 26'h200); tick;
    checks++; if (wake_bitmap !== 4'b0000) begin errors++; $display("FAIL midrst_late_200 got %b want 0000", wake_bitmap); end
    drive(0, 0, 0, 0, 1, 26'h300); tick;
    checks++; if (wake_bitmap !== 4'b0000 || thread_waiting !== 4'b0000) begin errors++;
      $display("FAIL midrst_late_300 got w=%b tw=%b want 0000 0000", wake_bitmap, thread_waiting); end
    drive(0, 0, 0, 0, 0, 0); tick;
  endtask
  task automatic rand_step(input bit allow_miss);
    int free [$];
    int q [$];
    bit [N-1:0] w, exp_wake;
    logic mv, rdy, rv, pv;
    logic [1:0] mt;
    logic [AW-1:0] ma, ra, pa;
    int r, a;
    w = mwait();
    for (int t = 0; t < N; t++) if (!w[t]) free.push_back(t);
    mv = allow_miss && free.size() > 0 && $urandom_range(0, 1) == 1;
    mt = free.size() > 0 ? 2'(free[$urandom_range(0, free.size() - 1)]) : 2'd0;
    ma = 26'h100 + 26'($urandom_range(0, 5));
    rdy = allow_miss ? $urandom_range(0, 2) != 0 : 1'b1;
    foreach (wt[k]) if (iss[k]) q.push_back(k);
    r = $urandom_range(0, 9);
    rv = 0; ra = 0;
    if (r < 4 && q.size() > 0) begin rv = 1; ra = AW'(q[$urandom_range(0, q.size() - 1)]); end
    else if (r == 9) begin rv = 1; ra = 26'h3FF; end
    drive(mv, mt, ma, rdy, rv, ra);
    exp_wake = '0;
    pv = l2_req_valid; pa = l2_req_addr;
    if (pv && rdy) begin
      a = int'(pa);
      checks++; if (!(wt.exists(a) && !iss[a])) begin errors++;
        $display("FAIL rand_req_legal got addr %h which is not an unissued pending line", pa); end
      else iss[a] = 1;
    end
    a = int'(ra);
    if (rv && wt.exists(a) && iss[a]) begin exp_wake |= wt[a]; wt.delete(a); iss.delete(a); end
    if (mv) begin
      if (rv && ma == ra) exp_wake |= N'(1) << mt;
      else if (wt.exists(int'(ma))) wt[int'(ma)] |= N'(1) << mt;
      else begin wt[int'(ma)] = N'(1) << mt; iss[int'(ma)] = 0; end
    end
    tick;
    checks++; if (wake_bitmap !== exp_wake) begin errors++;
      $display("FAIL rand_wake got %b want %b", wake_bitmap, exp_wake); end
    checks++; if (thread_waiting !== mwait()) begin errors++;
      $display("FAIL rand_waiting got %b want %b", thread_waiting, mwait()); end
    if (pv && !rdy) begin
      checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== pa) begin errors++;
        $display("FAIL rand_req_stable got v=%0b a=%h want v=1 a=%h", l2_req_valid, l2_req_addr, pa); end
    end
  endtask
  task automatic test_random;
    int guard = 0;
    wt.delete(); iss.delete();
    reset = 1; drive(0, 0, 0, 0, 0, 0); tick; reset = 0;
    repeat (400) rand_step(1);
    while (wt.num() > 0 && guard < 300) begin rand_step(0); guard++; end
    checks++; if (wt.num() != 0 || thread_waiting !== '0) begin errors++;
      $display("FAIL rand_drain got %0d lines pending tw=%b want 0 pending", wt.num(), thread_waiting); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_merge;
    test_round_robin;
    test_collision;
    test_stray;
    test_reset_midflight;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
